// File: rtl/ex_exec_unit.sv
// Execute stage of the in-order RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution with a combinational redirect, and the EX/MEM output register.
module ex_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [1:0]      a_sel_i,
    input  logic            b_sel_i,
    input  logic [3:0]      alu_op_i,
    input  logic [3:0]      br_op_i,
    input  logic [1:0]      fw_rs1_sel_i,
    input  logic [1:0]      fw_rs2_sel_i,
    input  logic [XLEN-1:0] mem_byp_i,
    input  logic [XLEN-1:0] wb_byp_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    output logic            br_taken_o,
    output logic [XLEN-1:0] br_target_o,
    output logic            flush_o,
    output logic            valid_o,
    output logic [XLEN-1:0] res_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [3:0] BR_BEQ   = 4'd1;
    localparam logic [3:0] BR_BNE   = 4'd2;
    localparam logic [3:0] BR_BLT   = 4'd3;
    localparam logic [3:0] BR_BGE   = 4'd4;
    localparam logic [3:0] BR_BLTU  = 4'd5;
    localparam logic [3:0] BR_BGEU  = 4'd6;
    localparam logic [3:0] BR_JAL   = 4'd7;
    localparam logic [3:0] BR_JALR  = 4'd8;

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] wb
    );
        case (sel)
            2'd1:    fwd_mux = mem;
            2'd2:    fwd_mux = wb;
            default: fwd_mux = rf;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_calc(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        logic [4:0]             shamt;
        a_s   = a;
        b_s   = b;
        shamt = b[4:0];
        case (op)
            ALU_ADD:  alu_calc = a + b;
            ALU_SUB:  alu_calc = a - b;
            ALU_SLL:  alu_calc = a << shamt;
            ALU_SLT:  alu_calc = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: alu_calc = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  alu_calc = a ^ b;
            ALU_SRL:  alu_calc = a >> shamt;
            ALU_SRA:  alu_calc = a_s >>> shamt;
            ALU_OR:   alu_calc = a | b;
            ALU_AND:  alu_calc = a & b;
            default:  alu_calc = '0;
        endcase
    endfunction

    // Branch conditions look at the forwarded registers, never at the ALU operands.
    function automatic logic br_cond(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        a_s = a;
        b_s = b;
        case (op)
            BR_BEQ:  br_cond = (a == b);
            BR_BNE:  br_cond = (a != b);
            BR_BLT:  br_cond = (a_s < b_s);
            BR_BGE:  br_cond = (a_s >= b_s);
            BR_BLTU: br_cond = (a < b);
            BR_BGEU: br_cond = (a >= b);
            BR_JAL:  br_cond = 1'b1;
            BR_JALR: br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    endfunction

    logic [XLEN-1:0] rs1_f;
    logic [XLEN-1:0] rs2_f;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] jalr_sum;
    logic            is_jump;
    logic [XLEN-1:0] res;

    always_comb begin
        rs1_f = fwd_mux(fw_rs1_sel_i, rs1_data_i, mem_byp_i, wb_byp_i);
        rs2_f = fwd_mux(fw_rs2_sel_i, rs2_data_i, mem_byp_i, wb_byp_i);

        case (a_sel_i)
            2'd0:    op_a = rs1_f;
            2'd1:    op_a = pc_i;
            default: op_a = '0;
        endcase
        op_b = b_sel_i ? imm_i : rs2_f;

        alu_res  = alu_calc(alu_op_i, op_a, op_b);
        is_jump  = (br_op_i == BR_JAL) || (br_op_i == BR_JALR);
        res      = is_jump ? (pc_i + XLEN'(4)) : alu_res;

        // JALR clears only bit 0; a misaligned bit 1 is deliberately passed on.
        jalr_sum = rs1_f + imm_i;
        if (br_op_i == BR_JALR) begin
            br_target_o = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            br_target_o = pc_i + imm_i;
        end

        br_taken_o = valid_i & br_cond(br_op_i, rs1_f, rs2_f);
        flush_o    = br_taken_o;
    end

    logic            valid_d,      valid_q;
    logic [XLEN-1:0] res_d,        res_q;
    logic [XLEN-1:0] store_data_d, store_data_q;
    logic [4:0]      rd_addr_d,    rd_addr_q;
    logic            rd_we_d,      rd_we_q;

    always_comb begin
        valid_d      = valid_i;
        res_d        = res;
        store_data_d = rs2_f;
        rd_addr_d    = rd_addr_i;
        rd_we_d      = rd_we_i & valid_i;
    end

    // EX/MEM register: bubbles still capture, but with the write enable dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            res_q        <= '0;
            store_data_q <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            res_q        <= res_d;
            store_data_q <= store_data_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
        end
    end

    assign valid_o      = valid_q;
    assign res_o        = res_q;
    assign store_data_o = store_data_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_we_o      = rd_we_q;

endmodule

// File: tb/tb_ex_exec_unit.sv
// Directed-vector bench for ex_exec_unit: forwarding, ALU, branches, jumps, bubbles, reset.
module tb_ex_exec_unit;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic [1:0]  a_sel_i;
    logic        b_sel_i;
    logic [3:0]  alu_op_i;
    logic [3:0]  br_op_i;
    logic [1:0]  fw_rs1_sel_i;
    logic [1:0]  fw_rs2_sel_i;
    logic [31:0] mem_byp_i;
    logic [31:0] wb_byp_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic        br_taken_o;
    logic [31:0] br_target_o;
    logic        flush_o;
    logic        valid_o;
    logic [31:0] res_o;
    logic [31:0] store_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_exec_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .pc_i         (pc_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .imm_i        (imm_i),
        .a_sel_i      (a_sel_i),
        .b_sel_i      (b_sel_i),
        .alu_op_i     (alu_op_i),
        .br_op_i      (br_op_i),
        .fw_rs1_sel_i (fw_rs1_sel_i),
        .fw_rs2_sel_i (fw_rs2_sel_i),
        .mem_byp_i    (mem_byp_i),
        .wb_byp_i     (wb_byp_i),
        .rd_addr_i    (rd_addr_i),
        .rd_we_i      (rd_we_i),
        .br_taken_o   (br_taken_o),
        .br_target_o  (br_target_o),
        .flush_o      (flush_o),
        .valid_o      (valid_o),
        .res_o        (res_o),
        .store_data_o (store_data_o),
        .rd_addr_o    (rd_addr_o),
        .rd_we_o      (rd_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        valid_i      = 1'b1;
        pc_i         = 32'h0000_0100;
        rs1_data_i   = 32'h0;
        rs2_data_i   = 32'h0;
        imm_i        = 32'h0;
        a_sel_i      = 2'd0;
        b_sel_i      = 1'b1;
        alu_op_i     = 4'd0;
        br_op_i      = 4'd0;
        fw_rs1_sel_i = 2'd0;
        fw_rs2_sel_i = 2'd0;
        mem_byp_i    = 32'h0;
        wb_byp_i     = 32'h0;
        rd_addr_i    = 5'd3;
        rd_we_i      = 1'b1;
    endtask

    logic [31:0] fw_exp [4];

    initial begin
        fw_exp[0] = 32'd1;
        fw_exp[1] = 32'd5;
        fw_exp[2] = 32'd9;
        fw_exp[3] = 32'd1;

        rst = 1'b0;
        set_defaults();
        #1;
        check("reset_valid", {31'b0, valid_o}, 32'h0);
        check("reset_res",   res_o,            32'h0);
        check("reset_rd_we", {31'b0, rd_we_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Forwarding select sweep on rs1
        rs1_data_i = 32'd1;
        mem_byp_i  = 32'd5;
        wb_byp_i   = 32'd9;
        rs2_data_i = 32'h0000_00AA;
        rd_addr_i  = 5'd7;
        for (int s = 0; s < 4; s++) begin
            fw_rs1_sel_i = 2'(s);
            step();
            check($sformatf("fwd_sel%0d", s), res_o, fw_exp[s]);
        end
        check("fwd_valid_o", {31'b0, valid_o},   32'h1);
        check("fwd_rd_we_o", {31'b0, rd_we_o},   32'h1);
        check("fwd_rd_addr", {27'b0, rd_addr_o}, 32'd7);
        check("fwd_store",   store_data_o,       32'h0000_00AA);

        // rs2 forwarded from mem goes to store data
        fw_rs1_sel_i = 2'd0;
        fw_rs2_sel_i = 2'd1;
        step();
        check("store_fwd_mem", store_data_o, 32'd5);
        fw_rs2_sel_i = 2'd0;

        // Arithmetic wrap and shifts
        rs1_data_i = 32'hFFFF_FFFF; imm_i = 32'd1; alu_op_i = 4'd0;
        step();
        check("add_wrap", res_o, 32'h0);
        rs1_data_i = 32'h0; rs2_data_i = 32'd1; b_sel_i = 1'b0; alu_op_i = 4'd1;
        step();
        check("sub_wrap", res_o, 32'hFFFF_FFFF);
        rs1_data_i = 32'h8000_0000; imm_i = 32'h24; b_sel_i = 1'b1; alu_op_i = 4'd7;
        step();
        check("sra", res_o, 32'hF800_0000);
        alu_op_i = 4'd6;
        step();
        check("srl", res_o, 32'h0800_0000);
        alu_op_i = 4'd12;
        step();
        check("alu_undef", res_o, 32'h0);

        // Signed/unsigned compares
        rs1_data_i = 32'hFFFF_FFFF; rs2_data_i = 32'd1; b_sel_i = 1'b0; alu_op_i = 4'd3;
        step();
        check("slt", res_o, 32'd1);
        alu_op_i = 4'd4;
        step();
        check("sltu", res_o, 32'd0);

        pc_i = 32'h0000_0200; imm_i = 32'h10; rd_we_i = 1'b0;
        br_op_i = 4'd3;
        #1;
        check("blt_taken",  {31'b0, br_taken_o}, 32'h1);
        check("blt_flush",  {31'b0, flush_o},    32'h1);
        check("blt_target", br_target_o,         32'h0000_0210);
        br_op_i = 4'd5;
        #1;
        check("bltu_taken", {31'b0, br_taken_o}, 32'h0);
        check("bltu_flush", {31'b0, flush_o},    32'h0);
        br_op_i = 4'd4;
        #1;
        check("bge_taken",  {31'b0, br_taken_o}, 32'h0);
        br_op_i = 4'd6;
        #1;
        check("bgeu_taken", {31'b0, br_taken_o}, 32'h1);
        step();
        check("branch_rd_we", {31'b0, rd_we_o}, 32'h0);

        // JALR with rs1 forwarded from WB
        pc_i = 32'h0000_0100; rs1_data_i = 32'h0; wb_byp_i = 32'h0000_2001;
        fw_rs1_sel_i = 2'd2; imm_i = 32'd4; br_op_i = 4'd8; alu_op_i = 4'd0;
        b_sel_i = 1'b1; rd_we_i = 1'b1;
        #1;
        check("jalr_taken",  {31'b0, br_taken_o}, 32'h1);
        check("jalr_target", br_target_o,         32'h0000_2004);
        step();
        check("jalr_link",   res_o,               32'h0000_0104);

        // JAL backwards
        fw_rs1_sel_i = 2'd0; imm_i = 32'hFFFF_FFF8; br_op_i = 4'd7;
        #1;
        check("jal_target", br_target_o, 32'h0000_00F8);
        step();
        check("jal_link",   res_o,       32'h0000_0104);

        // Bubble with an otherwise-taken BEQ
        valid_i = 1'b0; br_op_i = 4'd1; rs1_data_i = 32'd7; rs2_data_i = 32'd7;
        rd_we_i = 1'b1;
        #1;
        check("bubble_taken", {31'b0, br_taken_o}, 32'h0);
        check("bubble_flush", {31'b0, flush_o},    32'h0);
        step();
        check("bubble_rd_we", {31'b0, rd_we_o},    32'h0);
        check("bubble_valid", {31'b0, valid_o},    32'h0);
        valid_i = 1'b1;
        #1;
        check("beq_taken", {31'b0, br_taken_o}, 32'h1);

        // Asynchronous reset mid-stream
        br_op_i = 4'd0; rs1_data_i = 32'h0000_1234; imm_i = 32'h0; b_sel_i = 1'b1;
        alu_op_i = 4'd0; rd_addr_i = 5'd9;
        step();
        check("pre_rst_res", res_o, 32'h0000_1234);
        #1;
        rst = 1'b0;
        #1;
        check("rst_res",   res_o,              32'h0);
        check("rst_valid", {31'b0, valid_o},   32'h0);
        check("rst_rd_we", {31'b0, rd_we_o},   32'h0);
        check("rst_rdaddr",{27'b0, rd_addr_o}, 32'h0);
        check("rst_store", store_data_o,       32'h0);
        step();
        check("rst_hold_res", res_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_res",   res_o,            32'h0000_1234);
        check("post_rst_valid", {31'b0, valid_o}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_exec_unit.md
Name: ex_exec_unit

Overview:
- Execute-stage compute block for the in-order RV32I pipeline.
- Selects forwarded operands, performs the ALU operation and resolves branches/jumps.
- Register-file data plus mem/wb bypass values enter; branch redirect/flush leave combinationally; the result leaves through an EX/MEM output register.
- Sits between the ID/EX register and the memory stage.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- valid_i  in  1  instruction in EX is valid.
- pc_i  in  32  PC of the instruction.
- rs1_data_i / rs2_data_i  in  32  register-file read data.
- imm_i  in  32  sign-extended immediate.
- a_sel_i  in  2  operand A: 0=rs1, 1=pc, 2=zero, 3=zero.
- b_sel_i  in  1  operand B: 0=rs2, 1=imm.
- alu_op_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 give result 0.
- br_op_i  in  4  0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL, 8 JALR; 9-15 are treated as NONE.
- fw_rs1_sel_i / fw_rs2_sel_i  in  2  0=register file, 1=mem bypass, 2=wb bypass, 3=register file.
- mem_byp_i  in  32  bypass value from the MEM stage.
- wb_byp_i  in  32  bypass value from the WB stage.
- rd_addr_i  in  5  destination register.
- rd_we_i  in  1  destination write enable.
- br_taken_o  out  1  combinational: valid branch/jump taken.
- br_target_o  out  32  combinational redirect target.
- flush_o  out  1  combinational: equals br_taken_o.
- valid_o  out  1  registered valid.
- res_o  out  32  registered result.
- store_data_o  out  32  registered forwarded rs2 value.
- rd_addr_o  out  5  registered destination register.
- rd_we_o  out  1  registered write enable (already gated by valid).

Behaviour:
- Forwarding (combinational):
  - rs1_f = mux(fw_rs1_sel_i: rf/mem/wb); same rule for rs2_f.
  - Selection is purely by the select inputs; no address comparison happens inside this block.
- Operands: A = rs1_f / pc_i / 0 per a_sel_i. B = rs2_f / imm_i per b_sel_i.
- ALU (combinational, 32-bit, wrap-around):
  - ADD and SUB: modulo 2^32, no overflow flag.
  - Shifts use B[4:0] only. SRA replicates A[31].
  - SLT is signed, SLTU is unsigned; both produce 0 or 1.
- Branch condition compares rs1_f with rs2_f directly, never the ALU operands:
  - BEQ/BNE: equality and inequality.
  - BLT/BGE: signed.
  - BLTU/BGEU: unsigned.
  - JAL/JALR: always taken.
- Target:
  - Conditional branches and JAL: pc_i + imm_i.
  - JALR: (rs1_f + imm_i) with bit 0 cleared.
  - When nothing is taken, br_target_o = pc_i + imm_i (don't care).
  - No misalignment trap is raised; bit 1 is passed through.
- br_taken_o = valid_i & condition. flush_o = br_taken_o.
  - Combinational with zero latency; the fetch/decode stages act on it in the same cycle.
- Result mux: for JAL/JALR, res = pc_i + 4; otherwise res = ALU result.
  - Conditional branches still produce an ALU result; it is harmless because rd_we_i is 0 for them.
- Output register (1-cycle latency), updated on every rising edge:
  - valid_o <= valid_i.
  - res_o <= res.
  - store_data_o <= rs2_f.
  - rd_addr_o <= rd_addr_i.
  - rd_we_o <= rd_we_i & valid_i.
- There is no stall input; the upstream logic holds or bubbles the inputs.
- Reset (rst=0, asynchronous): all registered outputs go to 0 immediately and stay 0 while rst is low. Combinational outputs follow the inputs. The first capture happens on the first rising edge after rst rises.
- A bubble (valid_i=0) produces br_taken_o=0, flush_o=0 and rd_we_o=0 the next cycle, whatever the other inputs are.

Test Plan:
- Forwarding:
  - Setup: rs1_data_i=1, mem_byp_i=5, wb_byp_i=9, ADD with B=imm 0.
  - fw_rs1_sel_i cycling 0/1/2/3 -> res_o = 1/5/9/1 one cycle later.
- Arithmetic: ADD 0xFFFFFFFF+1 -> res_o=0. SUB 0-1 -> 0xFFFFFFFF. SRA 0x80000000 by imm 0x24 (shamt 4) -> 0xF8000000. SRL of the same -> 0x08000000.
- Compares: rs1=0xFFFFFFFF, rs2=1.
  - SLT -> 1, SLTU -> 0.
  - BLT taken, BLTU not taken; flush_o matches br_taken_o in the same cycle.
- Jumps:
  - JALR: pc=0x100, rs1=0x2001 forwarded from wb, imm=4 -> br_target_o=0x2004, res_o=0x104.
  - JAL: imm=-8 -> target 0xF8.
- Bubble: valid_i=0 with BEQ of equal operands, rd_we_i=1 -> br_taken_o=0, flush_o=0, rd_we_o=0.
- Reset: drive rst low mid-stream while res_o is nonzero -> all registered outputs go to 0 before the next clock edge, then resume normal capture after release.
